serial_comp_lsb: RTL and testbench
==================================

SERIAL_COMP_LSB -- requirements
Module: serial_comp_lsb

Interface
REQ-001 SHALL have the port `clock`, input, 1 bit: the single rising-edge clock.
REQ-002 SHALL have the port `reset`, input, 1 bit: synchronous, active-high reset, sampled on the `clock` rising edge.
REQ-003 SHALL have the port `start`, input, 1 bit: request to compare the current `A`/`B`.
REQ-004 SHALL have the port `A`, input, 32 bits: first operand, sampled only on an accepted `start`.
REQ-005 SHALL have the port `B`, input, 32 bits: second operand, sampled only on an accepted `start`.
REQ-006 SHALL have the port `busy`, output, 1 bit: high while a comparison is in progress.
REQ-007 SHALL have the port `done`, output, 1 bit: one-cycle pulse marking valid results.
REQ-008 SHALL have the port `EQ0`, output, 1 bit: registered result, A == B.
REQ-009 SHALL have the port `GT0`, output, 1 bit: registered result, A > B.
REQ-010 SHALL have the port `LT0`, output, 1 bit: registered result, A < B.

Function
REQ-011 SHALL be a multicycle comparator that scans the operands LSB-first, 2 bits per cycle, over 16 steps: pair 0 = bits[1:0] up to pair 15 = bits[31:30].
REQ-012 Step rule:
- pair A != pair B: eq_r = 0, gt_r = (pairA > pairB).
- pair A == pair B: eq_r and gt_r are unchanged.
- Consequence: the most significant differing pair dominates.
REQ-013 At accept, eq_r = 1 and gt_r = 0.
REQ-014 FSM states and transitions:
- IDLE -> RUN on `start`.
- RUN -> DONE after pair 15 is processed.
- DONE -> IDLE unconditionally, or DONE -> RUN if `start` is high in that cycle.
REQ-015 `start` SHALL be accepted only in IDLE or DONE; `start` in RUN SHALL be ignored, with no restart and no operand reload.
REQ-016 On accept SHALL latch `A`/`B` into shift registers and clear the 4-bit step counter to 0.
REQ-017 Latency: if `start` is accepted at edge k, `done` SHALL be high for exactly the one cycle after edge k+16.
REQ-018 `busy` SHALL be high exactly while in RUN.
REQ-019 `EQ0`/`GT0`/`LT0` SHALL update only on the RUN->DONE transition and hold until the next completion.
REQ-020 `LT0` = ~EQ0 & ~GT0; exactly one of the three outputs is high after the first completion.
REQ-021 The step counter wraps 15->0 only on the transition to DONE; no other wrap SHALL occur.

Reset
REQ-022 When `reset` is high on a rising edge: state = IDLE, busy = 0, done = 0, EQ0 = 0, GT0 = 0, LT0 = 0, counter = 0, shift registers = 0.
REQ-023 Reset mid-RUN SHALL abort the comparison with no `done` pulse; `start` asserted during a reset cycle SHALL be ignored.

Configuration
REQ-024 The macro `SIGNED_CMP_EN` selects signedness:
- Defined: operands are two's complement; bit 31 of both A and B is inverted at latch time; all other logic is unchanged.
- Undefined: the comparison is unsigned.

Structure
REQ-025 Package `comp_pkg` SHALL hold:
- CMP_WIDTH = 32, CMP_STEP = 2, CMP_STEPS = 16.
- A state typedef {IDLE, RUN, DONE}.
REQ-026 Sub-module `comp_step_2` SHALL implement the combinational step rule: inputs 2-bit a, 2-bit b, eq_in, gt_in; outputs eq_out, gt_out.
- One instance operates on the shift-register LSB pair.
- Shift registers shift right by 2 each RUN cycle.

Verification
REQ-027 A = 0x0000_0001, B = 0x8000_0000, unsigned build -> `done` after 16 edges; EQ0 = 0, GT0 = 0, LT0 = 1.
REQ-028 Same operands, `SIGNED_CMP_EN` build -> EQ0 = 0, GT0 = 1, LT0 = 0.
REQ-029 A = B = 0xDEAD_BEEF -> EQ0 = 1, GT0 = 0, LT0 = 0.
REQ-030 A = 0x0000_0003, B = 0x0000_0002, then a new `start` at cycle 5 of RUN with A = 0, B = 0xFFFF_FFFF -> the second start is ignored; the result is GT0 = 1; `busy` stays high for 16 cycles.
REQ-031 `reset` asserted at RUN cycle 8 -> no `done` pulse; all outputs 0; a subsequent `start` with A = 5, B = 9 -> LT0 = 1 after 16 edges.
REQ-032 Back-to-back operation: `start` held high in the DONE cycle -> RUN re-entered immediately; two `done` pulses 17 cycles apart; results are correct for each operand pair.

Source files
------------

// File: rtl/serial_comp_lsb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : comp_pkg
// Description : Shared constants and state encoding for the LSB-first
//               serial 32-bit comparator (serial_comp_lsb).
//               CMP_WIDTH  - operand width in bits
//               CMP_STEP   - bits compared per RUN cycle
//               CMP_STEPS  - number of RUN cycles per comparison
//               CMP_CNT_W  - width of the step counter
//               state_t    - controller state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package comp_pkg;

    localparam int CMP_WIDTH = 32;
    localparam int CMP_STEP  = 2;
    localparam int CMP_STEPS = 16;
    localparam int CMP_CNT_W = $clog2(CMP_STEPS);

    // Encoding 2'b11 is unused; the controller recovers from it to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : comp_pkg
`default_nettype wire

// File: rtl/serial_comp_lsb_step.sv
`default_nettype none
// ============================================================================
// Module      : comp_step_2
// Description : Combinational 2-bit step of the LSB-first comparator.
//               A differing pair overrides the running verdict; an equal
//               pair passes it through. Because pairs arrive LSB-first,
//               the most significant differing pair has the last word.
// Ports       : a, b           - current 2-bit operand pairs
//               eq_in, gt_in   - running verdict from earlier (lower) pairs
//               eq_out, gt_out - updated verdict
// Revision    : 1.0 - initial release
// ============================================================================
module comp_step_2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       eq_in,
    input  logic       gt_in,
    output logic       eq_out,
    output logic       gt_out
);

    always_comb begin
        eq_out = eq_in;
        gt_out = gt_in;
        if (a != b) begin
            eq_out = 1'b0;
            gt_out = (a > b);
        end
    end

endmodule : comp_step_2
`default_nettype wire

// File: rtl/serial_comp_lsb.sv
`default_nettype none
// ============================================================================
// Module      : serial_comp_lsb
// Description : Multicycle 32-bit magnitude comparator. Operands are latched
//               on an accepted start and scanned LSB-first, 2 bits per
//               cycle, over 16 RUN cycles. Results are registered on the
//               RUN->DONE transition and held until the next completion.
// Build macro : SIGNED_CMP_EN - when defined, operands are two's complement
//               (sign bit of both operands inverted at latch time);
//               otherwise the comparison is unsigned.
// Ports       : clock  - rising-edge clock
//               reset  - synchronous active-high reset
//               start  - compare request (accepted in IDLE or DONE only)
//               A, B   - operands, sampled on an accepted start
//               busy   - high while in RUN
//               done   - one-cycle pulse when results become valid
//               EQ0    - A == B
//               GT0    - A >  B
//               LT0    - A <  B
// Revision    : 1.0 - initial release
// ============================================================================
module serial_comp_lsb
    import comp_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CMP_WIDTH-1:0] A,
    input  logic [CMP_WIDTH-1:0] B,
    output logic                 busy,
    output logic                 done,
    output logic                 EQ0,
    output logic                 GT0,
    output logic                 LT0
);

    localparam logic [CMP_CNT_W-1:0] c_last_step = CMP_CNT_W'(CMP_STEPS - 1);

    state_t                 r_state;
    logic [CMP_WIDTH-1:0]   r_a;
    logic [CMP_WIDTH-1:0]   r_b;
    logic [CMP_CNT_W-1:0]   r_cnt;
    logic                   r_eq;
    logic                   r_gt;

    logic [CMP_WIDTH-1:0]   w_a_load;
    logic [CMP_WIDTH-1:0]   w_b_load;
    logic                   w_eq_next;
    logic                   w_gt_next;

`ifdef SIGNED_CMP_EN
    // Flipping the sign bit maps two's complement order onto unsigned order,
    // so the rest of the datapath stays identical between builds.
    assign w_a_load = {~A[CMP_WIDTH-1], A[CMP_WIDTH-2:0]};
    assign w_b_load = {~B[CMP_WIDTH-1], B[CMP_WIDTH-2:0]};
`else
    assign w_a_load = A;
    assign w_b_load = B;
`endif

    comp_step_2 u_step (
        .a      (r_a[CMP_STEP-1:0]),
        .b      (r_b[CMP_STEP-1:0]),
        .eq_in  (r_eq),
        .gt_in  (r_gt),
        .eq_out (w_eq_next),
        .gt_out (w_gt_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            EQ0     <= 1'b0;
            GT0     <= 1'b0;
            LT0     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_a     <= w_a_load;
                        r_b     <= w_b_load;
                        r_cnt   <= '0;
                        r_eq    <= 1'b1;
                        r_gt    <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end

                RUN: begin
                    // start is deliberately not looked at here: no restart,
                    // no operand reload while a comparison is in flight.
                    r_a   <= r_a >> CMP_STEP;
                    r_b   <= r_b >> CMP_STEP;
                    r_eq  <= w_eq_next;
                    r_gt  <= w_gt_next;
                    // Natural 15->0 wrap coincides with the move to DONE.
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last_step) begin
                        r_state <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        EQ0     <= w_eq_next;
                        GT0     <= w_gt_next;
                        LT0     <= ~w_eq_next & ~w_gt_next;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : serial_comp_lsb
`default_nettype wire

// File: tb/tb_serial_comp_lsb.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_comp_lsb
// Description : Directed self-checking bench for serial_comp_lsb. Expected
//               results are hand-computed; vectors whose verdict depends on
//               signedness carry both answers and pick one via SIGNED_CMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_comp_lsb;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        EQ0;
    logic        GT0;
    logic        LT0;

    int n_checks = 0;
    int n_fail   = 0;

    serial_comp_lsb dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .EQ0   (EQ0),
        .GT0   (GT0),
        .LT0   (LT0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle before sampling or driving.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present operands with start for exactly one edge.
    task automatic do_start(input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        A     = a;
        B     = b;
        tick();
        start = 1'b0;
    endtask

    // Called right after the accept edge. Returns edges until done is seen
    // (-1 if the bound expires) and the number of sampled busy cycles.
    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles   = -1;
        busy_cnt = busy ? 1 : 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (done) begin
                cycles = n;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        A     = 32'h1;
        B     = 32'h2;
        tick();
        tick();
        reset = 1'b0;
        start = 1'b0;
        n_checks++;
        if ({busy, done, EQ0, GT0, LT0} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000", {busy, done, EQ0, GT0, LT0});
        end
        tick();
        tick();
        n_checks++;
        if ({busy, done} !== 2'b0) begin
            n_fail++;
            $display("FAIL reset_start_ignored: busy/done got %b expected 00", {busy, done});
        end
    endtask

    task automatic test_vectors();
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic [2:0]  vexp [8]; // {EQ,GT,LT}
        int cyc, bc;
        va[0] = 32'h0000_0001; vb[0] = 32'h8000_0000;
        va[1] = 32'hDEAD_BEEF; vb[1] = 32'hDEAD_BEEF;
        va[2] = 32'h4000_0000; vb[2] = 32'h3FFF_FFFF;
        va[3] = 32'h0000_0010; vb[3] = 32'h0000_000F;
        va[4] = 32'h7FFF_FFFF; vb[4] = 32'hFFFF_FFFF;
        va[5] = 32'h0000_0000; vb[5] = 32'h0000_0000;
        va[6] = 32'h1234_5678; vb[6] = 32'h1234_5679;
        va[7] = 32'hFFFF_FFFE; vb[7] = 32'hFFFF_FFFF;
`ifdef SIGNED_CMP_EN
        vexp[0] = 3'b010; // 1 > -2^31
        vexp[4] = 3'b010; // max positive > -1
`else
        vexp[0] = 3'b001;
        vexp[4] = 3'b001;
`endif
        vexp[1] = 3'b100;
        vexp[2] = 3'b010;
        vexp[3] = 3'b010;
        vexp[5] = 3'b100;
        vexp[6] = 3'b001;
        vexp[7] = 3'b001; // -2 < -1 signed, and smaller unsigned
        for (int i = 0; i < 8; i++) begin
            do_start(va[i], vb[i]);
            wait_done(cyc, bc);
            n_checks++;
            if (cyc !== 16) begin
                n_fail++;
                $display("FAIL vec%0d_latency: got %0d edges expected 16", i, cyc);
            end
            n_checks++;
            if (bc !== 16) begin
                n_fail++;
                $display("FAIL vec%0d_busy_cycles: got %0d expected 16", i, bc);
            end
            n_checks++;
            if ({EQ0, GT0, LT0} !== vexp[i]) begin
                n_fail++;
                $display("FAIL vec%0d_result: A=%h B=%h got EQ/GT/LT=%b expected %b",
                         i, va[i], vb[i], {EQ0, GT0, LT0}, vexp[i]);
            end
            tick();
            n_checks++;
            if ({done, busy, EQ0, GT0, LT0} !== {2'b00, vexp[i]}) begin
                n_fail++;
                $display("FAIL vec%0d_hold: done/busy/EQ/GT/LT got %b expected %b",
                         i, {done, busy, EQ0, GT0, LT0}, {2'b00, vexp[i]});
            end
        end
    endtask

    task automatic test_start_ignored();
        int n, bc;
        n  = -1;
        do_start(32'h0000_0003, 32'h0000_0002);
        bc = busy ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            // Edge k+5 sees start high in the middle of RUN.
            if (k == 5) begin
                start = 1'b1;
                A     = 32'h0000_0000;
                B     = 32'hFFFF_FFFF;
            end
            tick();
            if (k == 5) start = 1'b0;
            if (done) begin
                n = k;
                break;
            end
            if (busy) bc++;
        end
        n_checks++;
        if (n !== 16) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d edges expected 16", n);
        end
        n_checks++;
        if (bc !== 16) begin
            n_fail++;
            $display("FAIL ignore_busy_cycles: got %0d expected 16", bc);
        end
        n_checks++;
        if ({EQ0, GT0, LT0} !== 3'b010) begin
            n_fail++;
            $display("FAIL ignore_result: got EQ/GT/LT=%b expected 010", {EQ0, GT0, LT0});
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int cyc, bc, seen;
        do_start(32'hFFFF_FFFF, 32'h0000_0000);
        for (int k = 0; k < 7; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({busy, done, EQ0, GT0, LT0} !== 5'b0) begin
            n_fail++;
            $display("FAIL abort_outputs: got %b expected 00000", {busy, done, EQ0, GT0, LT0});
        end
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done || busy) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d active cycles expected 0", seen);
        end
        do_start(32'd5, 32'd9);
        wait_done(cyc, bc);
        n_checks++;
        if (cyc !== 16) begin
            n_fail++;
            $display("FAIL after_abort_latency: got %0d edges expected 16", cyc);
        end
        n_checks++;
        if ({EQ0, GT0, LT0} !== 3'b001) begin
            n_fail++;
            $display("FAIL after_abort_result: got EQ/GT/LT=%b expected 001", {EQ0, GT0, LT0});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        do_start(32'h0000_1234, 32'h0000_1234);
        wait_done(cyc, bc);
        n_checks++;
        if (cyc !== 16 || {EQ0, GT0, LT0} !== 3'b100) begin
            n_fail++;
            $display("FAIL b2b_first: got %0d edges EQ/GT/LT=%b expected 16 edges 100",
                     cyc, {EQ0, GT0, LT0});
        end
        // Still in the DONE cycle: request the next comparison now.
        do_start(32'h0000_0005, 32'h0000_0009);
        n_checks++;
        if ({busy, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_reenter: busy/done got %b expected 10", {busy, done});
        end
        wait_done(cyc, bc);
        n_checks++;
        if (cyc + 1 !== 17) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles between done pulses expected 17", cyc + 1);
        end
        n_checks++;
        if ({EQ0, GT0, LT0} !== 3'b001) begin
            n_fail++;
            $display("FAIL b2b_second: got EQ/GT/LT=%b expected 001", {EQ0, GT0, LT0});
        end
        tick();
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        #2;
        test_reset();
        test_vectors();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_comp_lsb
`default_nettype wire
